// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame instruction cache.
//   Parameter SETS : number of frames (power of two, 2..256).
//   CLK            : rising-edge clock.
//   nRST           : synchronous active-high reset.
//   imemREN        : datapath instruction-read request.
//   imemaddr[31:0] : datapath word-aligned byte address.
//   ihit           : imemload carries the requested word this cycle.
//   imemload[31:0] : instruction word to the datapath (0 when no hit).
//   iREN           : read request to the memory controller.
//   iaddr[31:0]    : memory-controller read address (0 when idle).
//   iload[31:0]    : memory-controller read data.
//   iwait          : memory busy; iload is valid when iREN=1 and iwait=0.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 32 - 2 - IW;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [SETS-1:0] r_valid;
    logic [TW-1:0]   r_tag  [SETS];
    logic [31:0]     r_data [SETS];
    logic [31:0]     r_miss_addr;

    logic [IW-1:0]   w_index;
    logic [TW-1:0]   w_tag;
    logic [IW-1:0]   w_fill_index;
    logic [TW-1:0]   w_fill_tag;
    logic            w_lookup_hit;
    logic            w_miss;
    logic            w_fill;

    assign w_index      = imemaddr[2+IW-1:2];
    assign w_tag        = imemaddr[31:2+IW];
    assign w_fill_index = r_miss_addr[2+IW-1:2];
    assign w_fill_tag   = r_miss_addr[31:2+IW];

    always_comb begin
        w_lookup_hit = 1'b0;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        w_next_state = r_state;
        ihit         = 1'b0;
        imemload     = '0;
        iREN         = 1'b0;
        iaddr        = '0;

        if (r_state == IDLE && imemREN) begin
            w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
            w_miss       = !w_lookup_hit;
        end
        w_fill = (r_state == FETCH) && !iwait && !nRST;

        case (r_state)
            IDLE:    if (w_miss) w_next_state = FETCH;
            FETCH:   if (!iwait) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase

        // Outputs are forced quiet while reset is asserted, even if stale
        // valid bits or an in-flight fill would otherwise drive them.
        if (!nRST) begin
            ihit = w_lookup_hit;
            if (w_lookup_hit) imemload = r_data[w_index];
            iREN = (r_state == FETCH);
            if (r_state == FETCH) iaddr = r_miss_addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_fill) r_valid[w_fill_index] <= 1'b1;
            if (w_miss) r_miss_addr <= imemaddr;
        end
    end

    // Tag and data arrays carry no reset; validity alone gates their use.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= iload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed and randomized checks of icache against a
// frame-level reference model (word address + data per frame, a pending
// fill flag and its address).
module tb_icache;
    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    int errors = 0;
    int checks = 0;

    // reference model
    bit          m_valid [SETS];
    logic [29:0] m_waddr [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_fetching;
    logic [31:0] m_miss;

    // expectations for the current cycle
    bit          e_raw_hit;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_addr;

    icache #(.SETS(SETS)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait)
    );

    always #5 CLK = ~CLK;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-cycle and compute what the model expects this cycle.
    task automatic drive(input logic rst, input logic ren, input logic [31:0] a,
                         input logic w, input logic [31:0] ld);
        int i;
        @(negedge CLK);
        nRST = rst; imemREN = ren; imemaddr = a; iwait = w; iload = ld;
        #1;
        i = idx_of(a);
        e_raw_hit = !m_fetching && ren && m_valid[i] && (m_waddr[i] == a[31:2]);
        e_hit  = !rst && e_raw_hit;
        e_load = e_hit ? m_data[i] : 32'h0;
        e_ren  = !rst && m_fetching;
        e_addr = e_ren ? m_miss : 32'h0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ihit"},     {31'h0, ihit}, {31'h0, e_hit});
        chk({tag, ".imemload"}, imemload,      e_load);
        chk({tag, ".iREN"},     {31'h0, iREN}, {31'h0, e_ren});
        chk({tag, ".iaddr"},    iaddr,         e_addr);
    endtask

    // Advance one clock and apply the same rules to the model.
    task automatic tick();
        int i;
        @(posedge CLK);
        if (nRST) begin
            for (int k = 0; k < SETS; k++) m_valid[k] = 1'b0;
            m_fetching = 1'b0;
            m_miss = 32'h0;
        end else if (m_fetching) begin
            if (!iwait) begin
                i = idx_of(m_miss);
                m_valid[i] = 1'b1;
                m_waddr[i] = m_miss[31:2];
                m_data[i]  = iload;
                m_fetching = 1'b0;
            end
        end else if (imemREN && !e_raw_hit) begin
            m_fetching = 1'b1;
            m_miss = imemaddr;
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic ren,
                        input logic [31:0] a, input logic w, input logic [31:0] ld);
        drive(rst, ren, a, w, ld);
        check_model(tag);
        tick();
    endtask

    initial begin
        nRST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        m_fetching = 1'b0; m_miss = '0;
        for (int k = 0; k < SETS; k++) begin
            m_valid[k] = 1'b0; m_waddr[k] = '0; m_data[k] = '0;
        end

        // reset
        step("rst0", 1, 1, 32'h40, 1, 32'h0);
        drive(1, 1, 32'h40, 1, 32'h0);
        check_model("rst1");
        chk("rst.ihit", {31'h0, ihit}, 32'h0);
        chk("rst.iREN", {31'h0, iREN}, 32'h0);
        tick();

        // cold miss on 0x40, 2 wait cycles
        drive(0, 1, 32'h40, 1, 32'h0);
        check_model("cold.miss");
        chk("cold.miss.ihit", {31'h0, ihit}, 32'h0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 32'h40, (c < 2) ? 1'b1 : 1'b0, (c < 2) ? 32'h0 : 32'h2408_0005);
            check_model("cold.fetch");
            chk("cold.fetch.iREN", {31'h0, iREN}, 32'h1);
            chk("cold.fetch.iaddr", iaddr, 32'h40);
            tick();
        end
        drive(0, 1, 32'h40, 1, 32'h0);
        check_model("cold.hit");
        chk("cold.hit.ihit", {31'h0, ihit}, 32'h1);
        chk("cold.hit.data", imemload, 32'h2408_0005);
        tick();

        // warm hit
        drive(0, 1, 32'h40, 1, 32'h0);
        check_model("warm");
        chk("warm.ihit", {31'h0, ihit}, 32'h1);
        chk("warm.iREN", {31'h0, iREN}, 32'h0);
        tick();

        // conflict on index 0
        step("conf.miss80", 0, 1, 32'h80, 1, 32'h0);
        step("conf.fill80", 0, 1, 32'h80, 0, 32'h1111_1111);
        drive(0, 1, 32'h80, 1, 32'h0);
        check_model("conf.hit80");
        chk("conf.hit80.data", imemload, 32'h1111_1111);
        tick();
        drive(0, 1, 32'h40, 1, 32'h0);
        check_model("conf.miss40");
        chk("conf.miss40.ihit", {31'h0, ihit}, 32'h0);
        tick();
        step("conf.fill40", 0, 1, 32'h40, 0, 32'h2408_0005);
        step("conf.hit40", 0, 1, 32'h40, 1, 32'h0);

        // address change and request drop mid-fill
        step("chg.miss44", 0, 1, 32'h44, 1, 32'h0);
        drive(0, 0, 32'h48, 1, 32'h0);
        check_model("chg.wait");
        chk("chg.wait.iaddr", iaddr, 32'h44);
        tick();
        drive(0, 0, 32'h48, 0, 32'h2222_2222);
        check_model("chg.fill");
        chk("chg.fill.iaddr", iaddr, 32'h44);
        tick();
        drive(0, 1, 32'h48, 1, 32'h0);
        check_model("chg.miss48");
        chk("chg.miss48.ihit", {31'h0, ihit}, 32'h0);
        tick();
        step("chg.fill48", 0, 1, 32'h48, 0, 32'h3333_3333);
        drive(0, 1, 32'h44, 1, 32'h0);
        check_model("chg.hit44");
        chk("chg.hit44.data", imemload, 32'h2222_2222);
        tick();

        // reset mid-fill
        step("rmf.miss4c", 0, 1, 32'h4C, 1, 32'h0);
        step("rmf.rst", 1, 1, 32'h4C, 0, 32'hDEAD_BEEF);
        drive(0, 1, 32'h4C, 1, 32'h0);
        check_model("rmf.after");
        chk("rmf.after.iREN", {31'h0, iREN}, 32'h0);
        chk("rmf.after.ihit", {31'h0, ihit}, 32'h0);
        tick();
        step("rmf.fill", 0, 1, 32'h4C, 0, 32'h4444_4444);
        step("rmf.hit", 0, 1, 32'h4C, 1, 32'h0);

        // no request
        drive(0, 0, 32'h4C, 1, 32'h0);
        check_model("noreq");
        chk("noreq.ihit", {31'h0, ihit}, 32'h0);
        chk("noreq.load", imemload, 32'h0);
        chk("noreq.iREN", {31'h0, iREN}, 32'h0);
        tick();

        // randomized traffic over a small address pool to force conflicts
        for (int n = 0; n < 600; n++) begin
            step("rand",
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                 32'($urandom_range(0, 63)) << 2,
                 $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0,
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
